// File: rtl/led_fader.sv
// led_fader: per-LED brightness stage placed after the LED rotator.
// A lit input channel is driven at full brightness. Once it goes dark, its
// level ramps down linearly on every decay strobe and is rendered through a
// shared PWM counter, which leaves a fading "comet" trail behind the rotator.
module led_fader #(
  parameter int LED_COUNT   = 4,
  parameter int PWM_WIDTH   = 8,
  parameter int DECAY_WIDTH = 16,
  parameter int DECAY_STEP  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [LED_COUNT-1:0] i_led,
  input  logic                 i_en,
  output logic [LED_COUNT-1:0] o_led,
  output logic                 o_busy
);

  localparam logic [PWM_WIDTH-1:0] MAX  = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] STEP = PWM_WIDTH'(DECAY_STEP);

  logic [PWM_WIDTH-1:0]   pwm_cnt;
  logic [DECAY_WIDTH-1:0] prescaler;
  logic                   decay_stb;
  logic [PWM_WIDTH-1:0]   level [LED_COUNT];
  logic [LED_COUNT-1:0]   level_nz;

  // Free-running PWM counter shared by every channel, so all channels stay phase-aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
    end
  end

  // Decay prescaler: the carry out of the counter becomes a one-clock strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prescaler <= '0;
      decay_stb <= 1'b0;
    end else begin
      {decay_stb, prescaler} <= {1'b0, prescaler} + (DECAY_WIDTH + 1)'(1);
    end
  end

  // Level update per channel: disable clears, a lit input beats decay, decay saturates at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LED_COUNT; i++) begin
        level[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LED_COUNT; i++) begin
        if (!i_en) begin
          level[i] <= '0;
        end else if (i_led[i]) begin
          level[i] <= MAX;
        end else if (decay_stb) begin
          if (level[i] > STEP) begin
            level[i] <= level[i] - STEP;
          end else begin
            level[i] <= '0;
          end
        end
      end
    end
  end

  // Registered PWM drive; full level is forced on so it never blinks at the counter wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_led <= '0;
    end else begin
      for (int i = 0; i < LED_COUNT; i++) begin
        o_led[i] <= i_en && ((level[i] == MAX) || (level[i] > pwm_cnt));
      end
    end
  end

  // Busy flag: any channel still holding a nonzero level.
  always_comb begin
    level_nz = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      level_nz[i] = (level[i] != '0);
    end
  end

  assign o_busy = |level_nz;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed bench for led_fader with a small configuration
// (MAX = 15, decay strobe every 8 clocks, step 4). Edge numbers in the
// comments count rising edges since reset release; inputs are driven and
// outputs sampled on the falling edge.
module tb_led_fader;

  localparam int LED_COUNT = 4;

  logic                 i_clk;
  logic                 i_rst_n;
  logic [LED_COUNT-1:0] i_led;
  logic                 i_en;
  logic [LED_COUNT-1:0] o_led;
  logic                 o_busy;

  int vectors;
  int miscompares;
  int cyc;
  logic [15:0] pat [LED_COUNT];

  led_fader #(
    .LED_COUNT  (LED_COUNT),
    .PWM_WIDTH  (4),
    .DECAY_WIDTH(3),
    .DECAY_STEP (4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_led  (i_led),
    .i_en   (i_en),
    .o_led  (o_led),
    .o_busy (o_busy)
  );

  // Free-running clock, period 10.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic applyStimulus(input logic [LED_COUNT-1:0] led, input logic en);
    i_led = led;
    i_en  = en;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic advanceTo(input int target);
    while (cyc < target) tick();
  endtask

  // Sample o_led after each of n edges; bit k of pat[ch] is the k-th sample.
  task automatic captureWindow(input int n);
    for (int c = 0; c < LED_COUNT; c++) pat[c] = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      for (int c = 0; c < LED_COUNT; c++) pat[c][k] = o_led[c];
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    i_rst_n     = 1'b0;
    applyStimulus(4'b1111, 1'b1);

    // Reset holds everything dark even with all inputs lit.
    repeat (3) @(negedge i_clk);
    checkOutput("rst_led", {12'b0, o_led}, 16'h0000);
    checkOutput("rst_busy", {15'b0, o_busy}, 16'h0000);

    // Release reset between edges; the next rising edge is edge 1.
    applyStimulus(4'b0000, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc     = 0;

    // Fade: one-clock pulse on channel 0 captured at edge 1.
    applyStimulus(4'b0001, 1'b1);
    tick();                                                     // 1
    checkOutput("lit_lat1", {12'b0, o_led}, 16'h0000);
    checkOutput("lit_busy", {15'b0, o_busy}, 16'h0001);
    applyStimulus(4'b0000, 1'b1);
    tick();                                                     // 2
    checkOutput("lit_lat2", {12'b0, o_led}, 16'h0001);
    captureWindow(7);                                           // 3..9, level 15
    checkOutput("fade_15", pat[0], 16'h007F);
    captureWindow(8);                                           // 10..17, level 11, pwm 9..15,0
    checkOutput("fade_11", pat[0], 16'h0083);
    captureWindow(8);                                           // 18..25, level 7, pwm 1..8
    checkOutput("fade_7", pat[0], 16'h003F);
    captureWindow(7);                                           // 26..32, level 3, pwm 9..15
    checkOutput("fade_3a", pat[0], 16'h0000);
    checkOutput("busy_hold", {15'b0, o_busy}, 16'h0001);
    tick();                                                     // 33, level 3, pwm 0; level -> 0
    checkOutput("fade_3b", {12'b0, o_led}, 16'h0001);
    checkOutput("busy_fall", {15'b0, o_busy}, 16'h0000);
    captureWindow(8);                                           // 34..41, level 0
    checkOutput("fade_0", pat[0], 16'h0000);

    // Priority: re-light channel 1 on the strobe edge 65 while its level is 7.
    applyStimulus(4'b0010, 1'b1);
    tick();                                                     // 42
    applyStimulus(4'b0000, 1'b1);
    advanceTo(57);
    captureWindow(7);                                           // 58..64, level 7, pwm 9..15
    checkOutput("prio_l7", pat[1], 16'h0000);
    applyStimulus(4'b0010, 1'b1);
    tick();                                                     // 65
    checkOutput("prio_edge", {12'b0, o_led}, 16'h0002);
    applyStimulus(4'b0000, 1'b1);
    captureWindow(8);                                           // 66..73, level 15
    checkOutput("prio_15", pat[1], 16'h00FF);
    captureWindow(8);                                           // 74..81, level 11, pwm 9..15,0
    checkOutput("prio_11", pat[1], 16'h0083);

    // Enable: channel 2 at level 7 at edge 98, then drop i_en.
    applyStimulus(4'b0100, 1'b1);
    tick();                                                     // 82
    applyStimulus(4'b0000, 1'b1);
    advanceTo(98);
    checkOutput("en_pre", {12'b0, o_led}, 16'h0004);
    checkOutput("en_pre_busy", {15'b0, o_busy}, 16'h0001);
    applyStimulus(4'b0000, 1'b0);
    tick();                                                     // 99
    checkOutput("en_blank", {12'b0, o_led}, 16'h0000);
    checkOutput("en_clear", {15'b0, o_busy}, 16'h0000);
    applyStimulus(4'b1111, 1'b0);
    tick();                                                     // 100
    checkOutput("en_over_led", {12'b0, o_led}, 16'h0000);
    checkOutput("en_over_busy", {15'b0, o_busy}, 16'h0000);
    applyStimulus(4'b0000, 1'b1);
    tick();                                                     // 101
    tick();                                                     // 102
    checkOutput("en_rise", {12'b0, o_led}, 16'h0000);
    checkOutput("en_rise_busy", {15'b0, o_busy}, 16'h0000);

    // Trail: rotate one-hot every 16 edges starting at edge 113.
    advanceTo(112);
    applyStimulus(4'b0001, 1'b1);
    advanceTo(128);
    applyStimulus(4'b0010, 1'b1);
    advanceTo(144);
    applyStimulus(4'b0100, 1'b1);
    captureWindow(16);                                          // 145..160
    checkOutput("trail_a0", pat[0], 16'h0007);
    checkOutput("trail_a1", pat[1], 16'h01FF);
    checkOutput("trail_a2", pat[2], 16'hFFFE);
    checkOutput("trail_a3", pat[3], 16'h0000);
    applyStimulus(4'b1000, 1'b1);
    captureWindow(16);                                          // 161..176, ch2 spans pwm wrap
    checkOutput("trail_b0", pat[0], 16'h0000);
    checkOutput("trail_b1", pat[1], 16'h0007);
    checkOutput("trail_b2", pat[2], 16'h01FF);
    checkOutput("trail_b3", pat[3], 16'hFFFE);
    applyStimulus(4'b0001, 1'b1);
    captureWindow(16);                                          // 177..192, bit 3 -> bit 0
    checkOutput("trail_c0", pat[0], 16'hFFFE);
    checkOutput("trail_c1", pat[1], 16'h0000);
    checkOutput("trail_c2", pat[2], 16'h0007);
    checkOutput("trail_c3", pat[3], 16'h01FF);

    // Asynchronous reset mid-operation clears outputs before the next edge.
    applyStimulus(4'b1111, 1'b1);
    tick();                                                     // 193
    tick();                                                     // 194
    checkOutput("rst_pre", {12'b0, o_led}, 16'h000F);
    checkOutput("rst_pre_busy", {15'b0, o_busy}, 16'h0001);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_async", {12'b0, o_led}, 16'h0000);
    checkOutput("rst_async_busy", {15'b0, o_busy}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
